// File: rtl/out_port_reader.sv
// Read-handshake front end for the switch output ports: one request FSM and one FIFO per port,
// merged round-robin onto a single ready/valid stream.
module out_port_reader #(
   parameter int NUM_PORTS  = 4,
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [NUM_PORTS*DW-1:0]      addr_out,
   input  logic [NUM_PORTS*DW-1:0]      data_out,
   input  logic [NUM_PORTS-1:0]         valid_out,
   input  logic [NUM_PORTS-1:0]         rcv_rdy,
   output logic [NUM_PORTS-1:0]         data_rd,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [$clog2(NUM_PORTS)-1:0] m_port,
   output logic [DW-1:0]                m_addr,
   output logic [DW-1:0]                m_data,
   output logic [NUM_PORTS-1:0]         timeout,
   output logic [NUM_PORTS-1:0]         spurious
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int WW = $clog2(RD_TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [WW-1:0] WCNT_MAX  = WW'(RD_TIMEOUT);
   localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t               state_q [NUM_PORTS];
   state_t               state_d [NUM_PORTS];
   logic [WW-1:0]        wcnt_q  [NUM_PORTS];
   logic [WW-1:0]        wcnt_d  [NUM_PORTS];
   logic [CW-1:0]        cnt_q   [NUM_PORTS];
   logic [CW-1:0]        cnt_d   [NUM_PORTS];
   logic [AW-1:0]        wptr_q  [NUM_PORTS];
   logic [AW-1:0]        wptr_d  [NUM_PORTS];
   logic [AW-1:0]        rptr_q  [NUM_PORTS];
   logic [AW-1:0]        rptr_d  [NUM_PORTS];
   logic [2*DW-1:0]      mem_q   [NUM_PORTS][FIFO_DEPTH];
   logic [NUM_PORTS-1:0] data_rd_q, data_rd_d, timeout_q, timeout_d, spurious_q, spurious_d;
   logic [NUM_PORTS-1:0] issue, wr_en, pop, nonempty;
   logic [PW-1:0]        rr_q, rr_d, gnt_q, gnt_d, gnt;
   logic                 lock_q, lock_d, handshake, found;
   logic [2*DW-1:0]      head;

   always_comb begin
      issue    = '0;
      nonempty = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         issue[p]    = (state_q[p] == IDLE) && en && rcv_rdy[p] && (cnt_q[p] != FULL_CNT);
         nonempty[p] = (cnt_q[p] != '0);
      end
   end

   // Next-state logic; REQ and WAIT always run to completion regardless of en/rcv_rdy
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         state_d[p] = state_q[p];
         wcnt_d[p]  = wcnt_q[p];
         case (state_q[p])
            IDLE: if (issue[p]) state_d[p] = REQ;
            REQ: begin
               state_d[p] = WAIT;
               wcnt_d[p]  = WW'(1);
            end
            WAIT: begin
               if (valid_out[p] || (wcnt_q[p] == WCNT_MAX)) state_d[p] = IDLE;
               else                                         wcnt_d[p]  = wcnt_q[p] + WW'(1);
            end
            default: state_d[p] = IDLE;
         endcase
      end
   end

   always_comb begin
      data_rd_d  = '0;
      timeout_d  = '0;
      spurious_d = '0;
      wr_en      = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         data_rd_d[p]  = issue[p];
         wr_en[p]      = (state_q[p] == WAIT) && valid_out[p];
         timeout_d[p]  = (state_q[p] == WAIT) && !valid_out[p] && (wcnt_q[p] == WCNT_MAX);
         spurious_d[p] = (state_q[p] != WAIT) && valid_out[p];
      end
   end

   // Grant is frozen while a presented beat waits for m_ready
   always_comb begin
      gnt   = rr_q;
      found = 1'b0;
      if (lock_q) begin
         gnt = gnt_q;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && nonempty[(int'(rr_q) + i) % NUM_PORTS]) begin
               gnt   = PW'((int'(rr_q) + i) % NUM_PORTS);
               found = 1'b1;
            end
         end
      end
      m_valid   = |nonempty;
      handshake = m_valid && m_ready;
      head      = mem_q[gnt][rptr_q[gnt]];
      m_port    = m_valid ? gnt : '0;
      m_addr    = m_valid ? head[2*DW-1:DW] : '0;
      m_data    = m_valid ? head[DW-1:0] : '0;
      lock_d    = m_valid && !m_ready;
      gnt_d     = gnt;
      rr_d      = rr_q;
      if (handshake) rr_d = (gnt == LAST_PORT) ? '0 : gnt + PW'(1);
      pop = '0;
      for (int p = 0; p < NUM_PORTS; p++) pop[p] = handshake && (gnt == PW'(p));
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         cnt_d[p]  = cnt_q[p] + CW'(wr_en[p]) - CW'(pop[p]);
         wptr_d[p] = wptr_q[p] + AW'(wr_en[p]);
         rptr_d[p] = rptr_q[p] + AW'(pop[p]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= IDLE;
            wcnt_q[p]  <= '0;
            cnt_q[p]   <= '0;
            wptr_q[p]  <= '0;
            rptr_q[p]  <= '0;
         end
         data_rd_q  <= '0;
         timeout_q  <= '0;
         spurious_q <= '0;
         rr_q       <= '0;
         gnt_q      <= '0;
         lock_q     <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= state_d[p];
            wcnt_q[p]  <= wcnt_d[p];
            cnt_q[p]   <= cnt_d[p];
            wptr_q[p]  <= wptr_d[p];
            rptr_q[p]  <= rptr_d[p];
         end
         data_rd_q  <= data_rd_d;
         timeout_q  <= timeout_d;
         spurious_q <= spurious_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         lock_q     <= lock_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (wr_en[p]) mem_q[p][wptr_q[p]] <= {addr_out[p*DW +: DW], data_out[p*DW +: DW]};
      end
   end

   assign data_rd  = data_rd_q;
   assign timeout  = timeout_q;
   assign spurious = spurious_q;

endmodule

// File: tb/tb_out_port_reader.sv
// Bench for out_port_reader: directed handshake scenarios plus a randomized run checked
// against a queue-based model of the per-port FIFOs and round-robin merge.
module tb_out_port_reader;
   localparam int NP = 4;
   localparam int DW = 8;
   localparam int RT = 4;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         stamp;
   } ent_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic [NP*DW-1:0] addr_out, data_out;
   logic [NP-1:0]   valid_out, rcv_rdy, data_rd, timeout, spurious;
   logic            m_valid, m_ready;
   logic [1:0]      m_port;
   logic [DW-1:0]   m_addr, m_data;

   int   errors = 0;
   int   checks = 0;
   ent_t mq [NP][$];

   always #5 clk = ~clk;

   out_port_reader #(.NUM_PORTS(NP), .DW(DW), .FIFO_DEPTH(8), .RD_TIMEOUT(RT)) dut (
      .clk(clk), .reset(reset), .en(en), .addr_out(addr_out), .data_out(data_out),
      .valid_out(valid_out), .rcv_rdy(rcv_rdy), .data_rd(data_rd), .m_valid(m_valid),
      .m_ready(m_ready), .m_port(m_port), .m_addr(m_addr), .m_data(m_data),
      .timeout(timeout), .spurious(spurious)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lane(input int p, input logic [7:0] a, input logic [7:0] d);
      addr_out[p*DW +: DW] = a;
      data_out[p*DW +: DW] = d;
   endtask

   task automatic do_reset;
      reset = 1'b0; en = 1'b0; valid_out = '0; rcv_rdy = '0; m_ready = 1'b0;
      addr_out = '0; data_out = '0;
      tick; tick;
      reset = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b0; en = 1'b0; valid_out = '0; rcv_rdy = '0; m_ready = 1'b0;
      addr_out = '0; data_out = '0;
      #1;
      checks++;
      if ({data_rd, timeout, spurious, m_valid, m_port, m_addr, m_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {data_rd, timeout, spurious, m_valid, m_port, m_addr, m_data});
      end
      tick; reset = 1'b1; tick; tick;
      checks++;
      if ({data_rd, timeout, spurious, m_valid} !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got %h want 0", {data_rd, timeout, spurious, m_valid});
      end
   endtask

   task automatic test_single;
      do_reset;
      en = 1'b1; m_ready = 1'b1; rcv_rdy[0] = 1'b1;
      tick;
      checks++;
      if (data_rd !== 4'b0001) begin errors++; $display("FAIL single_data_rd: got %b want 0001", data_rd); end
      rcv_rdy[0] = 1'b0;
      tick;
      checks++;
      if (data_rd !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b want 0000", data_rd); end
      drive_lane(0, 8'h02, 8'hA5); valid_out[0] = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL single_no_early_valid: got %b want 0", m_valid); end
      tick;
      valid_out = '0;
      checks++;
      if ({m_valid, m_port, m_addr, m_data} !== {1'b1, 2'd0, 8'h02, 8'hA5}) begin
         errors++;
         $display("FAIL single_output: got v=%b p=%0d a=%h d=%h want v=1 p=0 a=02 d=a5", m_valid, m_port, m_addr, m_data);
      end
      tick;
      checks++;
      if ({m_valid, data_rd} !== 5'b0) begin errors++; $display("FAIL single_drained: got %b want 0", {m_valid, data_rd}); end
   endtask

   task automatic test_all_ports;
      logic [7:0]    exp_d [NP][2];
      logic [1:0]    got_p [8];
      logic [7:0]    got_a [8], got_d [8];
      int            nrd [NP], nresp [NP];
      int            nout;
      logic [NP-1:0] rd_prev;
      do_reset;
      for (int p = 0; p < NP; p++) begin
         nrd[p] = 0; nresp[p] = 0;
         exp_d[p][0] = 8'($urandom); exp_d[p][1] = 8'($urandom);
      end
      nout = 0; rd_prev = '0;
      en = 1'b1; m_ready = 1'b1; rcv_rdy = '1;
      for (int c = 0; c < 30; c++) begin
         tick;
         if (m_valid) begin
            if (nout < 8) begin got_p[nout] = m_port; got_a[nout] = m_addr; got_d[nout] = m_data; end
            nout++;
         end
         valid_out = '0;
         for (int p = 0; p < NP; p++) begin
            if (rd_prev[p] && nresp[p] < 2) begin
               drive_lane(p, 8'(p * 16 + nresp[p]), exp_d[p][nresp[p]]);
               valid_out[p] = 1'b1;
               nresp[p]++;
            end
            if (data_rd[p]) begin
               nrd[p]++;
               if (nrd[p] == 2) rcv_rdy[p] = 1'b0;
            end
         end
         rd_prev = data_rd;
      end
      checks++;
      if (nout != 8) begin errors++; $display("FAIL all_ports_count: got %0d want 8", nout); end
      for (int k = 0; k < 8 && k < nout; k++) begin
         checks++;
         if (got_p[k] !== 2'(k % 4) || got_a[k] !== 8'((k % 4) * 16 + k / 4) || got_d[k] !== exp_d[k % 4][k / 4]) begin
            errors++;
            $display("FAIL all_ports_order[%0d]: got p=%0d a=%h d=%h want p=%0d a=%h d=%h", k, got_p[k], got_a[k],
                     got_d[k], k % 4, 8'((k % 4) * 16 + k / 4), exp_d[k % 4][k / 4]);
         end
      end
   endtask

   task automatic test_fill;
      int            npulse, nresp, nout;
      logic [NP-1:0] rd_prev;
      logic [7:0]    got_a [8], got_d [8];
      logic [1:0]    got_p [8];
      do_reset;
      npulse = 0; nresp = 0; nout = 0; rd_prev = '0;
      en = 1'b1; m_ready = 1'b0; rcv_rdy = 4'b0010;
      for (int c = 0; c < 60; c++) begin
         tick;
         valid_out = '0;
         if (rd_prev[1]) begin
            drive_lane(1, 8'(8'h40 + nresp), 8'(8'h10 + nresp));
            valid_out[1] = 1'b1;
            nresp++;
         end
         if (data_rd[1]) npulse++;
         rd_prev = data_rd;
      end
      checks++;
      if (npulse != 8) begin errors++; $display("FAIL fill_pulses: got %0d want 8", npulse); end
      checks++;
      if ({m_valid, m_port, m_data} !== {1'b1, 2'd1, 8'h10}) begin
         errors++;
         $display("FAIL fill_hold: got v=%b p=%0d d=%h want v=1 p=1 d=10", m_valid, m_port, m_data);
      end
      rcv_rdy = '0; m_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (m_valid) begin
            if (nout < 8) begin got_p[nout] = m_port; got_a[nout] = m_addr; got_d[nout] = m_data; end
            nout++;
         end
         tick;
      end
      checks++;
      if (nout != 8) begin errors++; $display("FAIL fill_drain_count: got %0d want 8", nout); end
      for (int k = 0; k < 8 && k < nout; k++) begin
         checks++;
         if (got_p[k] !== 2'd1 || got_a[k] !== 8'(8'h40 + k) || got_d[k] !== 8'(8'h10 + k)) begin
            errors++;
            $display("FAIL fill_drain[%0d]: got p=%0d a=%h d=%h want p=1 a=%h d=%h", k, got_p[k], got_a[k], got_d[k],
                     8'(8'h40 + k), 8'(8'h10 + k));
         end
      end
   endtask

   task automatic test_timeout;
      do_reset;
      en = 1'b1; m_ready = 1'b1; rcv_rdy[2] = 1'b1;
      tick;
      checks++;
      if (data_rd !== 4'b0100) begin errors++; $display("FAIL timeout_req: got %b want 0100", data_rd); end
      rcv_rdy = '0;
      for (int k = 1; k <= RT; k++) begin
         tick;
         checks++;
         if ({timeout, m_valid} !== 5'b0) begin
            errors++;
            $display("FAIL timeout_early[%0d]: got %b want 0", k, {timeout, m_valid});
         end
      end
      tick;
      checks++;
      if ({timeout, m_valid} !== {4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL timeout_pulse: got %b want 01000", {timeout, m_valid});
      end
      rcv_rdy[2] = 1'b1;
      tick;
      checks++;
      if ({timeout, data_rd} !== {4'b0000, 4'b0100}) begin
         errors++;
         $display("FAIL timeout_reissue: got %b want 00000100", {timeout, data_rd});
      end
      rcv_rdy = '0;
      tick;
      drive_lane(2, 8'h33, 8'h5C); valid_out[2] = 1'b1;
      tick;
      valid_out = '0;
      checks++;
      if ({m_valid, m_port, m_addr, m_data} !== {1'b1, 2'd2, 8'h33, 8'h5C}) begin
         errors++;
         $display("FAIL timeout_after_read: got v=%b p=%0d a=%h d=%h want v=1 p=2 a=33 d=5c", m_valid, m_port, m_addr, m_data);
      end
      tick;
   endtask

   task automatic test_spurious;
      do_reset;
      en = 1'b1; m_ready = 1'b1;
      drive_lane(3, 8'hEE, 8'h77); valid_out[3] = 1'b1;
      tick;
      valid_out = '0;
      checks++;
      if ({spurious, m_valid} !== {4'b1000, 1'b0}) begin
         errors++;
         $display("FAIL spurious_idle: got %b want 10000", {spurious, m_valid});
      end
      tick;
      checks++;
      if ({spurious, m_valid} !== 5'b0) begin errors++; $display("FAIL spurious_width: got %b want 0", {spurious, m_valid}); end
      rcv_rdy[3] = 1'b1;
      tick;
      checks++;
      if (data_rd !== 4'b1000) begin errors++; $display("FAIL spurious_req_rd: got %b want 1000", data_rd); end
      rcv_rdy = '0; valid_out[3] = 1'b1;
      tick;
      valid_out = '0;
      checks++;
      if (spurious !== 4'b1000) begin errors++; $display("FAIL spurious_req: got %b want 1000", spurious); end
      repeat (RT) tick;
      checks++;
      if ({timeout, m_valid} !== {4'b1000, 1'b0}) begin
         errors++;
         $display("FAIL spurious_req_timeout: got %b want 10000", {timeout, m_valid});
      end
   endtask

   task automatic test_reset_inflight;
      do_reset;
      en = 1'b1; m_ready = 1'b0; rcv_rdy = 4'b0011;
      tick;
      rcv_rdy = '0;
      tick;
      drive_lane(1, 8'h61, 8'h62); valid_out[1] = 1'b1;
      tick;
      valid_out = '0;
      checks++;
      if ({m_valid, m_port} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL inflight_pre: got v=%b p=%0d want v=1 p=1", m_valid, m_port);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({data_rd, timeout, spurious, m_valid, m_port, m_addr, m_data} !== '0) begin
         errors++;
         $display("FAIL inflight_reset: got %h want 0", {data_rd, timeout, spurious, m_valid, m_port, m_addr, m_data});
      end
      tick;
      reset = 1'b1;
      tick;
      drive_lane(0, 8'h99, 8'h98); valid_out[0] = 1'b1;
      tick;
      valid_out = '0;
      checks++;
      if ({spurious, m_valid, timeout} !== {4'b0001, 1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL inflight_late_valid: got %b want 000100000", {spurious, m_valid, timeout});
      end
      for (int k = 0; k < 6; k++) begin
         tick;
         checks++;
         if ({m_valid, timeout, data_rd} !== 9'b0) begin
            errors++;
            $display("FAIL inflight_quiet[%0d]: got %b want 0", k, {m_valid, timeout, data_rd});
         end
      end
   endtask

   task automatic test_random;
      int            cd [NP], busy_until [NP], to_due [NP];
      int            rr, lockp, cyc, ep, lat;
      bit            locked;
      logic          prev_en;
      logic [NP-1:0] prev_rdy, vis;
      logic [7:0]    a, d;
      do_reset;
      for (int p = 0; p < NP; p++) begin
         cd[p] = 0; busy_until[p] = 0; to_due[p] = -1;
         mq[p].delete();
      end
      rr = 0; locked = 1'b0; lockp = 0; cyc = 0; prev_en = 1'b0; prev_rdy = '0;
      for (int c = 0; c < 1560; c++) begin
         @(posedge clk); #1;
         cyc++;
         valid_out = '0;
         for (int p = 0; p < NP; p++) begin
            if (cd[p] > 0) begin
               cd[p]--;
               if (cd[p] == 0) begin
                  a = 8'($urandom); d = 8'($urandom);
                  drive_lane(p, a, d);
                  valid_out[p] = 1'b1;
                  mq[p].push_back('{a, d, cyc});
               end
            end
         end
         for (int p = 0; p < NP; p++) begin
            checks++;
            if (timeout[p] !== (cyc == to_due[p]) || spurious[p] !== 1'b0) begin
               errors++;
               $display("FAIL rand_timeout_spurious p%0d cyc%0d: got to=%b sp=%b want to=%b sp=0", p, cyc,
                        timeout[p], spurious[p], (cyc == to_due[p]));
            end
            if (data_rd[p]) begin
               checks++;
               if (cyc <= busy_until[p] || !prev_en || !prev_rdy[p]) begin
                  errors++;
                  $display("FAIL rand_data_rd_legal p%0d cyc%0d: got data_rd=1 want 0", p, cyc);
               end
               lat = $urandom_range(0, RT);
               cd[p] = lat;
               if (lat == 0) begin
                  to_due[p] = cyc + RT + 1;
                  busy_until[p] = cyc + RT + 1;
               end else begin
                  busy_until[p] = cyc + lat + 1;
               end
            end
         end
         if (c < 1500) begin
            en = ($urandom_range(0, 7) != 0);
            rcv_rdy = 4'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
         end else begin
            en = 1'b0; rcv_rdy = '0; m_ready = 1'b1;
         end
         prev_en = en; prev_rdy = rcv_rdy;
         @(negedge clk);
         for (int p = 0; p < NP; p++) vis[p] = (mq[p].size() > 0) && (mq[p][0].stamp < cyc);
         checks++;
         if (m_valid !== (|vis)) begin
            errors++;
            $display("FAIL rand_m_valid cyc%0d: got %b want %b", cyc, m_valid, |vis);
         end
         if (|vis) begin
            if (locked) ep = lockp;
            else begin
               ep = -1;
               for (int i = 0; i < NP; i++) if (ep < 0 && vis[(rr + i) % NP]) ep = (rr + i) % NP;
            end
            checks++;
            if (m_port !== 2'(ep) || m_addr !== mq[ep][0].a || m_data !== mq[ep][0].d) begin
               errors++;
               $display("FAIL rand_merge cyc%0d: got p=%0d a=%h d=%h want p=%0d a=%h d=%h", cyc, m_port, m_addr,
                        m_data, ep, mq[ep][0].a, mq[ep][0].d);
            end
            if (m_ready) begin
               void'(mq[ep].pop_front());
               rr = (ep + 1) % NP;
               locked = 1'b0;
            end else begin
               locked = 1'b1;
               lockp = ep;
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         checks++;
         if (mq[p].size() != 0) begin
            errors++;
            $display("FAIL rand_drain p%0d: got %0d left want 0", p, mq[p].size());
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_all_ports;
      test_fill;
      test_timeout;
      test_spurious;
      test_reset_inflight;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
